crank_cadence_meter: RTL
========================

// Module: crank_cadence_meter
// PURPOSE
//  Downstream consumer of the active-low crank sensor pulse nCrank (real sensor or crank generator).
//  - Synchronises and debounces nCrank; one accepted falling edge = one crank revolution.
//  - Measures the clock count between edges and divides it into 60*CLK_HZ to get cadence in RPM.
//  - Presents cadence, revolution count and a stopped flag to the display/trip logic.
// PARAMETERS
//  CLK_HZ      32768   core clock frequency in Hz
//  RPM_NUM     1966080 60*CLK_HZ, dividend for cadence; 21 bits
//  DEB_CYCLES  16      cycles nCrank must be stable before a level change is accepted
//  TIMEOUT_CYC 98304   clocks without an edge before cadence is forced to 0 (3 s)
//  PER_W       17      period counter width; must hold TIMEOUT_CYC
// PORTS
//  core_CLK      in   1   core clock, all logic on rising edge
//  core_Reset    in   1   synchronous reset, active-high
//  nCrank        in   1   raw crank pulse, active-low, asynchronous to core_CLK
//  cadence       out  8   last computed cadence in RPM, saturates at 255
//  cadence_valid out  1   1-cycle pulse when cadence is updated (new result or timeout)
//  crank_pulse   out  1   1-cycle pulse per accepted revolution edge
//  crank_count   out  16  accepted revolutions since reset, wraps 0xFFFF->0
//  stopped       out  1   1 while no valid period is held (after reset or timeout)
// BEHAVIOUR
//  Reset (core_Reset=1 at a clock edge)
//  - cadence=0, cadence_valid=0, crank_pulse=0, crank_count=0, stopped=1.
//  - Synchroniser and debounced level reset to 1; period counter 0; state WAIT_FIRST.
//  - Reset mid-DIVIDE aborts the division and produces no cadence_valid.
//  Input conditioning
//  - 2-flop synchroniser, then debounce: the debounced level changes only after the synchronised
//    input differs from it for DEB_CYCLES consecutive cycles; shorter glitches are discarded.
//  - Accepted edge = debounced 1->0; crank_pulse fires in that cycle (raw fall + 2 + DEB_CYCLES).
//  - crank_count increments on every accepted edge, in every state.
//  Period counter
//  - Cleared to 0 on each accepted edge, else +1 per cycle.
//  - Saturates at TIMEOUT_CYC; never wraps.
//  States
//  - WAIT_FIRST: no reference edge yet.
//    - Edge -> MEASURE; counter cleared; no division.
//  - MEASURE:
//    - Edge with period P = counter value in that cycle -> latch P, DIVIDE.
//    - Counter reaches TIMEOUT_CYC with no edge -> cadence=0, cadence_valid=1, stopped=1, WAIT_FIRST.
//    - Edge and timeout in the same cycle: the edge wins (division of P=TIMEOUT_CYC).
//  - DIVIDE: restoring divider RPM_NUM/P, one quotient bit per cycle, 21 cycles, truncating.
//    - The counter keeps running for the next period.
//    - Done -> cadence=min(Q,255), cadence_valid=1, stopped=0, MEASURE.
//    - cadence_valid lands in cycle E+22 after the edge cycle E.
//    - An edge during DIVIDE cannot occur: edge spacing >= 2*DEB_CYCLES=32 > 22.
//      The bench asserts this; if it occurs, RTL ignores it for timing but still counts it.
//    - Timeout cannot occur during DIVIDE.
//  - cadence holds its value between updates; cadence_valid is never high for two consecutive cycles.
// TESTING
//  - Reset: hold core_Reset 3 cycles -> all outputs at reset values, stopped=1, cadence=0.
//  - Steady 60 RPM: nCrank low 1000 cycles every 32768 cycles, 4 revs.
//    -> crank_count=4, first edge gives no cadence_valid, then cadence=60 each rev at E+22.
//  - 120 RPM: period 16384 -> cadence=120. Period 6000 (Q=327) -> cadence=255 (saturation).
//  - Glitch: 10-cycle low pulses on nCrank -> no crank_pulse, crank_count unchanged.
//    A 17-cycle low pulse -> one crank_pulse.
//  - Timeout: after a 60 RPM rev, no further edge.
//    -> at counter=98304: cadence=0, cadence_valid=1, stopped=1.
//    -> next edge gives crank_pulse only, no cadence; the following edge computes cadence.
//  - Reset mid-DIVIDE: assert core_Reset at E+10 -> no cadence_valid, outputs at reset values.
//    crank_count wraps: 65536 edges -> crank_count=0.

Source files
------------

// File: rtl/crank_cadence_meter_if.sv
`default_nettype none
// ============================================================================
//  Module      : crank_cadence_meter_if
//  Description : Crank sensor input and cadence result bundle between the
//                crank pulse source and the cadence meter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface crank_cadence_meter_if;
    logic        nCrank;
    logic [7:0]  cadence;
    logic        cadence_valid;
    logic        crank_pulse;
    logic [15:0] crank_count;
    logic        stopped;

    // Sensor / consumer side: drives the raw pulse, observes the results
    modport master (
        output nCrank,
        input  cadence, cadence_valid, crank_pulse, crank_count, stopped
    );

    // Meter side
    modport slave (
        input  nCrank,
        output cadence, cadence_valid, crank_pulse, crank_count, stopped
    );
endinterface
`default_nettype wire

// File: rtl/crank_cadence_meter.sv
`default_nettype none
// ============================================================================
//  Module      : crank_cadence_meter
//  Description : Synchronises and debounces the active-low crank pulse,
//                counts revolutions and converts the edge-to-edge period into
//                a cadence in RPM with a 21-step restoring divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module crank_cadence_meter #(
    parameter int CLK_HZ      = 32768,
    parameter int RPM_NUM     = 60 * CLK_HZ,
    parameter int DEB_CYCLES  = 16,
    parameter int TIMEOUT_CYC = 98304,
    parameter int PER_W       = 17
) (
    input  wire logic            core_CLK,
    input  wire logic            core_Reset,
    crank_cadence_meter_if.slave bus
);

    // Quotient length is fixed so the result latency does not depend on
    // the clock-rate parameters.
    localparam int                   c_DIV_W    = 21;
    localparam logic [4:0]           c_DIV_LAST = 5'd20;
    localparam logic [c_DIV_W-1:0]   c_RPM      = c_DIV_W'(RPM_NUM);
    localparam logic [PER_W-1:0]     c_TIMEOUT  = PER_W'(TIMEOUT_CYC);
    localparam int                   c_DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [c_DEB_W-1:0]   c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT_FIRST = 2'd0,
        S_MEASURE    = 2'd1,
        S_DIVIDE     = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_deb;
    logic [c_DEB_W-1:0]   r_deb_cnt;
    logic                 w_accept;
    logic                 r_edge;
    logic [15:0]          r_count;

    logic [PER_W-1:0]     r_per;

    logic                 w_start;
    logic                 w_timeout;
    logic                 w_done;

    logic [c_DIV_W-1:0]   r_dvd;
    logic [PER_W-1:0]     r_dvs;
    logic [PER_W-1:0]     r_rem;
    logic [c_DIV_W-2:0]   r_quot;
    logic [4:0]           r_div_cnt;
    logic [PER_W:0]       w_rem_sh;
    logic                 w_ge;
    logic [PER_W-1:0]     w_rem_sub;
    logic [PER_W-1:0]     w_rem_nxt;
    logic [c_DIV_W-1:0]   w_quot_nxt;
    logic [7:0]           w_cad_sat;

    logic [7:0]           r_cadence;
    logic                 r_valid;
    logic                 r_stopped;

    // Two-flop synchroniser; idles high (sensor released)
    always_ff @(posedge core_CLK) begin
        if (core_Reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.nCrank;
            r_sync2 <= r_sync1;
        end
    end

    // A revolution is accepted on the cycle the debounced level falls
    assign w_accept = (r_sync2 != r_deb) && (r_deb_cnt == c_DEB_LAST) && r_deb;

    // Debounce: follow the synchronised level only after it has differed for DEB_CYCLES cycles
    always_ff @(posedge core_CLK) begin
        if (core_Reset) begin
            r_deb     <= 1'b1;
            r_deb_cnt <= '0;
            r_edge    <= 1'b0;
            r_count   <= '0;
        end else begin
            r_edge <= w_accept;
            if (w_accept) begin
                r_count <= r_count + 16'd1;
            end
            if (r_sync2 != r_deb) begin
                if (r_deb_cnt == c_DEB_LAST) begin
                    r_deb     <= r_sync2;
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 1'b1;
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    // Period counter: restarts on each revolution, parks at the timeout value
    always_ff @(posedge core_CLK) begin
        if (core_Reset) begin
            r_per <= '0;
        end else if (r_edge) begin
            r_per <= '0;
        end else if (r_per != c_TIMEOUT) begin
            r_per <= r_per + 1'b1;
        end
    end

    // State register
    always_ff @(posedge core_CLK) begin
        if (core_Reset) begin
            r_state <= S_WAIT_FIRST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control strobes; an edge seen while dividing only counts as a revolution
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_timeout   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_WAIT_FIRST: begin
                if (r_edge) begin
                    w_state_nxt = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (r_edge) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_DIVIDE;
                end else if (r_per == c_TIMEOUT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_WAIT_FIRST;
                end
            end
            S_DIVIDE: begin
                if (r_div_cnt == c_DIV_LAST) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_MEASURE;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_FIRST;
            end
        endcase
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        w_rem_sh   = {r_rem, r_dvd[c_DIV_W-1]};
        w_ge       = (w_rem_sh >= {1'b0, r_dvs});
        w_rem_sub  = w_rem_sh[PER_W-1:0] - r_dvs;
        w_rem_nxt  = w_ge ? w_rem_sub : w_rem_sh[PER_W-1:0];
        w_quot_nxt = {r_quot, w_ge};
        w_cad_sat  = (|w_quot_nxt[c_DIV_W-1:8]) ? 8'hFF : w_quot_nxt[7:0];
    end

    // Divider datapath: load on the measuring edge, one quotient bit per cycle
    always_ff @(posedge core_CLK) begin
        if (core_Reset) begin
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_div_cnt <= '0;
        end else if (w_start) begin
            r_dvd     <= c_RPM;
            r_dvs     <= r_per;
            r_rem     <= '0;
            r_quot    <= '0;
            r_div_cnt <= '0;
        end else if (r_state == S_DIVIDE) begin
            r_dvd     <= {r_dvd[c_DIV_W-2:0], 1'b0};
            r_rem     <= w_rem_nxt;
            r_quot    <= w_quot_nxt[c_DIV_W-2:0];
            r_div_cnt <= r_div_cnt + 5'd1;
        end
    end

    // Result registers: updated on division completion or on timeout
    always_ff @(posedge core_CLK) begin
        if (core_Reset) begin
            r_cadence <= '0;
            r_valid   <= 1'b0;
            r_stopped <= 1'b1;
        end else begin
            r_valid <= 1'b0;
            if (w_done) begin
                r_cadence <= w_cad_sat;
                r_valid   <= 1'b1;
                r_stopped <= 1'b0;
            end else if (w_timeout) begin
                r_cadence <= '0;
                r_valid   <= 1'b1;
                r_stopped <= 1'b1;
            end
        end
    end

    assign bus.cadence       = r_cadence;
    assign bus.cadence_valid = r_valid;
    assign bus.crank_pulse   = r_edge;
    assign bus.crank_count   = r_count;
    assign bus.stopped       = r_stopped;

endmodule
`default_nettype wire
